apb_fabric_intc: RTL and testbench

- APB interconnect plus integrated interrupt controller between the CPU (APB master) and the SoC peripherals.
- Decodes the master address to one of three external slaves (sram, system, uart) or the internal interrupt-controller register block.
- Returns the selected slave's read data, ready and error signals to the master.
- Latches bus errors and external interrupt requests, and drives the CPU interrupt line.

---
 rtl/apb_fabric_intc_if.sv | 26 ++
 rtl/apb_fabric_intc.sv | 133 +++++++++++++
 tb/tb_apb_fabric_intc.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_fabric_intc_if.sv
// APB bus between the CPU master and the fabric: the master drives address/control/data,
// the fabric returns read data, ready and error.
interface apb_fabric_intc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH/8-1:0] pstb;
  logic                    pready;
  logic                    perr;

  modport master (
    output paddr, pwdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );
endinterface

// File: rtl/apb_fabric_intc.sv
// APB fabric: decodes the CPU bus to sram/system/uart or an internal interrupt controller
// that latches bus errors and level interrupts and drives the CPU interrupt line.
module apb_fabric_intc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_IRQ      = 8
) (
  input  logic                  clk,
  input  logic                  rts,
  apb_fabric_intc_if.slave      m,
  output logic                  sram_sel,
  output logic                  uart_sel,
  output logic                  system_sel,
  output logic                  sram_enable,
  output logic                  uart_enable,
  output logic                  system_enable,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [DATA_WIDTH-1:0] uart_rdata,
  input  logic [DATA_WIDTH-1:0] system_rdata,
  input  logic                  sram_ready,
  input  logic                  uart_ready,
  input  logic                  system_ready,
  input  logic                  sram_err,
  input  logic                  uart_err,
  input  logic                  system_err,
  input  logic [N_IRQ-1:0]      irq_in,
  output logic                  cpu_interrupt
);

  localparam int PW = N_IRQ + 1;
  localparam int NB = DATA_WIDTH / 8;

  logic                  hit_sram, hit_uart, hit_system, hit_intc, bad_off;
  logic                  xfer_done, err_evt, reg_we, wr_pend, wr_en;
  logic [DATA_WIDTH-1:0] bm, reg_rdata;
  logic [PW-1:0]         wr_bm, pend_clr;
  logic [PW-1:0]         pending, enable;
  logic [ADDR_WIDTH-1:0] erraddr;
  logic                  unused_bits;

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [NB-1:0] stb);
    logic [DATA_WIDTH-1:0] mask;
    for (int i = 0; i < DATA_WIDTH; i++) mask[i] = stb[i/8];
    return mask;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lowest_index(input logic [PW-1:0] v);
    logic [DATA_WIDTH-1:0] idx;
    idx = '1;
    for (int i = PW - 1; i >= 0; i--) if (v[i]) idx = DATA_WIDTH'(i);
    return idx;
  endfunction

  assign hit_system = (m.paddr[ADDR_WIDTH-1:16] == '0);
  assign hit_intc   = (m.paddr[ADDR_WIDTH-1:12] == (ADDR_WIDTH-12)'(32'h0000_2000));
  assign hit_uart   = (m.paddr[ADDR_WIDTH-1:8]  == (ADDR_WIDTH-8)'(32'h0010_0000));
  assign hit_sram   = (m.paddr[ADDR_WIDTH-1:28] == (ADDR_WIDTH-28)'(32'h8));
  assign bad_off    = (m.paddr[11:4] != '0);

  assign sram_sel      = m.psel & hit_sram;
  assign uart_sel      = m.psel & hit_uart;
  assign system_sel    = m.psel & hit_system;
  assign sram_enable   = m.psel & m.penable & hit_sram;
  assign uart_enable   = m.psel & m.penable & hit_uart;
  assign system_enable = m.psel & m.penable & hit_system;

  always_comb begin
    reg_rdata = '0;
    case (m.paddr[3:2])
      2'd0: reg_rdata = DATA_WIDTH'(pending);
      2'd1: reg_rdata = DATA_WIDTH'(enable);
      2'd2: reg_rdata = lowest_index(pending & enable);
      2'd3: reg_rdata = DATA_WIDTH'(erraddr);
    endcase
  end

  // Internal block and unmapped space answer in the access phase with no wait states.
  always_comb begin
    m.prdata = '0;
    m.pready = 1'b0;
    m.perr   = 1'b0;
    if (m.psel) begin
      if (hit_sram) begin
        m.prdata = sram_rdata;
        m.pready = sram_ready;
        m.perr   = sram_err;
      end else if (hit_uart) begin
        m.prdata = uart_rdata;
        m.pready = uart_ready;
        m.perr   = uart_err;
      end else if (hit_system) begin
        m.prdata = system_rdata;
        m.pready = system_ready;
        m.perr   = system_err;
      end else if (hit_intc) begin
        m.prdata = bad_off ? '0 : reg_rdata;
        m.pready = m.penable;
        m.perr   = m.penable & bad_off;
      end else begin
        m.pready = m.penable;
        m.perr   = m.penable;
      end
    end
  end

  assign xfer_done = m.psel & m.penable & m.pready;
  assign err_evt   = xfer_done & m.perr;
  assign reg_we    = xfer_done & hit_intc & m.pwrite & ~bad_off;
  assign wr_pend   = reg_we & (m.paddr[3:2] == 2'd0);
  assign wr_en     = reg_we & (m.paddr[3:2] == 2'd1);

  assign bm       = byte_mask(m.pstb);
  assign wr_bm    = bm[PW-1:0];
  assign pend_clr = wr_pend ? (m.pwdata[PW-1:0] & wr_bm) : '0;

  // Set terms are OR-ed after the clear so a simultaneous set wins.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      pending <= '0;
      enable  <= '0;
      erraddr <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | {irq_in, err_evt};
      if (wr_en) enable <= (enable & ~wr_bm) | (m.pwdata[PW-1:0] & wr_bm);
      if (err_evt) erraddr <= m.paddr;
    end
  end

  assign cpu_interrupt = |(pending & enable);

  assign unused_bits = ^{m.paddr[1:0], m.pwdata, bm};

endmodule

// File: tb/tb_apb_fabric_intc.sv
// Directed bench for apb_fabric_intc: table of combinational decode vectors plus
// hand-written APB sequences for the interrupt controller and reset behaviour.
module tb_apb_fabric_intc;

  logic        clk = 1'b0;
  logic        rts;
  logic        sram_sel, uart_sel, system_sel;
  logic        sram_enable, uart_enable, system_enable;
  logic [31:0] sram_rdata   = 32'hDEAD_BEEF;
  logic [31:0] uart_rdata   = 32'h0000_00A5;
  logic [31:0] system_rdata = 32'h1234_5678;
  logic        sram_ready, uart_ready, system_ready;
  logic        sram_err, uart_err, system_err;
  logic [7:0]  irq_in;
  logic        cpu_interrupt;

  logic        table_mode;
  logic [2:0]  slv_rdy, slv_err;
  int          wcnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] uart_wdata_seen = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  apb_fabric_intc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_fabric_intc #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_IRQ(8)) dut (
    .clk(clk), .rts(rts), .m(bus),
    .sram_sel(sram_sel), .uart_sel(uart_sel), .system_sel(system_sel),
    .sram_enable(sram_enable), .uart_enable(uart_enable), .system_enable(system_enable),
    .sram_rdata(sram_rdata), .uart_rdata(uart_rdata), .system_rdata(system_rdata),
    .sram_ready(sram_ready), .uart_ready(uart_ready), .system_ready(system_ready),
    .sram_err(sram_err), .uart_err(uart_err), .system_err(system_err),
    .irq_in(irq_in), .cpu_interrupt(cpu_interrupt)
  );

  always #5 clk = ~clk;

  // sram model: two wait states per access when not driven from the table
  always @(posedge clk) begin
    if (!sram_enable) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign sram_ready   = table_mode ? slv_rdy[2] : (sram_enable && wcnt >= 2);
  assign uart_ready   = table_mode ? slv_rdy[1] : 1'b1;
  assign system_ready = table_mode ? slv_rdy[0] : 1'b1;
  assign sram_err     = slv_err[2];
  assign uart_err     = slv_err[1];
  assign system_err   = slv_err[0];

  always @(negedge clk) begin
    if ($countones({sram_sel, uart_sel, system_sel}) > 1) overlap_cnt <= overlap_cnt + 1;
    if (uart_enable && uart_ready && bus.pwrite) uart_wdata_seen <= bus.pwdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] stb, input logic b2b,
                      output logic [31:0] rdata, output logic err);
    int waits;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata; bus.pstb = stb;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    waits = 0;
    #3;
    while (bus.pready !== 1'b1 && waits < 20) begin
      @(posedge clk); #4;
      waits++;
    end
    if (bus.pready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout addr %h: pready %b after %0d cycles, required 1", addr, bus.pready, waits);
    end
    rdata = bus.prdata;
    err   = bus.perr;
    @(posedge clk); #1;
    bus.penable = 1'b0;
    if (!b2b) bus.psel = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d, output logic e);
    xfer(1'b0, addr, 32'h0, 4'hF, 1'b0, d, e);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] stb,
                    output logic e);
    logic [31:0] d;
    xfer(1'b1, addr, data, stb, 1'b0, d, e);
  endtask

  typedef struct packed {
    logic        psel;
    logic        pen;
    logic [31:0] addr;
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_err;
    logic [2:0]  exp_sel;
    logic [2:0]  exp_en;
  } vec_t;

  localparam logic [31:0] PEND = 32'h0200_0000;
  localparam logic [31:0] ENA  = 32'h0200_0004;
  localparam logic [31:0] CAUS = 32'h0200_0008;
  localparam logic [31:0] EADR = 32'h0200_000C;

  vec_t vt [18];

  initial begin
    logic [31:0] d;
    logic        e;

    // psel pen addr rdy err | rdata ready err sel{sram,uart,sys} en
    vt[0]  = '{1'b0, 1'b0, 32'h8000_0010, 3'b111, 3'b000, 32'h0,         1'b0, 1'b0, 3'b000, 3'b000};
    vt[1]  = '{1'b1, 1'b0, 32'h8000_0010, 3'b000, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'b100, 3'b000};
    vt[2]  = '{1'b1, 1'b1, 32'h8000_0010, 3'b000, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'b100, 3'b100};
    vt[3]  = '{1'b1, 1'b1, 32'h8000_0010, 3'b100, 3'b000, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'b100, 3'b100};
    vt[4]  = '{1'b1, 1'b1, 32'h8FFF_FFFC, 3'b100, 3'b100, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b100, 3'b100};
    vt[5]  = '{1'b1, 1'b1, 32'h1000_00FF, 3'b010, 3'b000, 32'h0000_00A5, 1'b1, 1'b0, 3'b010, 3'b010};
    vt[6]  = '{1'b1, 1'b1, 32'h0000_FFFC, 3'b001, 3'b001, 32'h1234_5678, 1'b1, 1'b1, 3'b001, 3'b001};
    vt[7]  = '{1'b1, 1'b1, 32'h0000_0000, 3'b001, 3'b000, 32'h1234_5678, 1'b1, 1'b0, 3'b001, 3'b001};
    vt[8]  = '{1'b1, 1'b1, 32'h0001_0000, 3'b111, 3'b000, 32'h0,         1'b1, 1'b1, 3'b000, 3'b000};
    vt[9]  = '{1'b1, 1'b0, 32'h1000_0100, 3'b111, 3'b000, 32'h0,         1'b0, 1'b0, 3'b000, 3'b000};
    vt[10] = '{1'b1, 1'b1, 32'h1000_0100, 3'b111, 3'b000, 32'h0,         1'b1, 1'b1, 3'b000, 3'b000};
    vt[11] = '{1'b1, 1'b1, 32'h9000_0000, 3'b111, 3'b000, 32'h0,         1'b1, 1'b1, 3'b000, 3'b000};
    vt[12] = '{1'b1, 1'b1, 32'h01FF_FFFF, 3'b111, 3'b000, 32'h0,         1'b1, 1'b1, 3'b000, 3'b000};
    vt[13] = '{1'b1, 1'b0, 32'h0200_0004, 3'b111, 3'b000, 32'h0,         1'b0, 1'b0, 3'b000, 3'b000};
    vt[14] = '{1'b1, 1'b1, 32'h0200_0FFC, 3'b111, 3'b000, 32'h0,         1'b1, 1'b1, 3'b000, 3'b000};
    vt[15] = '{1'b1, 1'b1, 32'h0200_0008, 3'b111, 3'b000, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'b000, 3'b000};
    vt[16] = '{1'b0, 1'b1, 32'h1000_0000, 3'b111, 3'b111, 32'h0,         1'b0, 1'b0, 3'b000, 3'b000};
    vt[17] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 3'b111, 3'b000, 32'h0,         1'b1, 1'b1, 3'b000, 3'b000};

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstb = '0;
    rts = 1'b1; table_mode = 1'b1; slv_rdy = '0; slv_err = '0; irq_in = '0;

    // reset state
    repeat (2) @(posedge clk);
    #4;
    chk1("rst_cpu_interrupt", cpu_interrupt, 1'b0);
    chk1("rst_idle_pready", bus.pready, 1'b0);
    @(posedge clk); #1;
    rts = 1'b0;
    rd(PEND, d, e); chk("rst_pending", d, 32'h0);
    rd(ENA,  d, e); chk("rst_enable", d, 32'h0);
    rd(CAUS, d, e); chk("rst_cause", d, 32'hFFFF_FFFF);
    rd(EADR, d, e); chk("rst_erraddr", d, 32'h0);

    // decode / routing table
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      bus.psel = vt[i].psel; bus.penable = vt[i].pen; bus.paddr = vt[i].addr;
      bus.pwrite = 1'b0; slv_rdy = vt[i].rdy; slv_err = vt[i].err;
      #3;
      chk($sformatf("vec%0d_rdata", i), bus.prdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_ready_err", i), {30'h0, bus.pready, bus.perr},
          {30'h0, vt[i].exp_ready, vt[i].exp_err});
      chk($sformatf("vec%0d_sel_en", i), {26'h0, sram_sel, uart_sel, system_sel,
          sram_enable, uart_enable, system_enable}, {26'h0, vt[i].exp_sel, vt[i].exp_en});
    end
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; slv_err = '0;
    rts = 1'b1;
    @(posedge clk); #1;
    rts = 1'b0; table_mode = 1'b0;

    // 1: sram read with two wait states
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h8000_0010; bus.pstb = 4'hF;
    #3;
    chk("t1_setup_sel_en", {26'h0, sram_sel, uart_sel, system_sel, sram_enable, uart_enable, system_enable},
        {26'h0, 6'b100_000});
    chk1("t1_setup_pready", bus.pready, 1'b0);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #3;
    chk("t1_acc_sel_en", {26'h0, sram_sel, uart_sel, system_sel, sram_enable, uart_enable, system_enable},
        {26'h0, 6'b100_100});
    chk1("t1_wait1_pready", bus.pready, 1'b0);
    @(posedge clk); #4;
    chk1("t1_wait2_pready", bus.pready, 1'b0);
    @(posedge clk); #4;
    chk1("t1_done_pready", bus.pready, 1'b1);
    chk("t1_done_prdata", bus.prdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;

    // 2: uart write then system read, back to back
    xfer(1'b1, 32'h1000_0000, 32'h0000_0055, 4'hF, 1'b1, d, e);
    chk1("t2_uart_perr", e, 1'b0);
    xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, 1'b0, d, e);
    chk("t2_system_rdata", d, 32'h1234_5678);
    chk("t2_uart_wdata", uart_wdata_seen, 32'h0000_0055);
    chk("t2_sel_overlap", overlap_cnt, 32'h0);

    // 3: unmapped read latches bus error
    rd(32'h4000_0000, d, e);
    chk1("t3_unmapped_perr", e, 1'b1);
    chk("t3_unmapped_rdata", d, 32'h0);
    rd(PEND, d, e); chk("t3_pending", d, 32'h1);
    rd(EADR, d, e); chk("t3_erraddr", d, 32'h4000_0000);
    chk1("t3_cpu_int_masked", cpu_interrupt, 1'b0);

    // 4: enabled bus-error interrupt
    wr(PEND, 32'h1, 4'hF, e);
    wr(ENA, 32'h1, 4'hF, e);
    chk1("t4_enable_perr", e, 1'b0);
    chk1("t4_cpu_int_before", cpu_interrupt, 1'b0);
    slv_err = 3'b010;
    xfer(1'b1, 32'h1000_0004, 32'h0, 4'hF, 1'b0, d, e);
    slv_err = 3'b000;
    chk1("t4_uart_perr", e, 1'b1);
    chk1("t4_cpu_int_after", cpu_interrupt, 1'b1);
    rd(CAUS, d, e); chk("t4_cause", d, 32'h0);
    rd(EADR, d, e); chk("t4_erraddr", d, 32'h1000_0004);
    wr(PEND, 32'h1, 4'hF, e);
    chk1("t4_cpu_int_cleared", cpu_interrupt, 1'b0);

    // 5: byte-strobed enable, irq pulse, set-beats-clear
    wr(ENA, 32'hFFFF_FF06, 4'b0001, e);
    rd(ENA, d, e); chk("t5_enable_bytewr", d, 32'h6);
    @(posedge clk); #1; irq_in = 8'h02;
    @(posedge clk); #1; irq_in = 8'h00;
    rd(PEND, d, e); chk("t5_pending", d, 32'h4);
    rd(CAUS, d, e); chk("t5_cause", d, 32'h2);
    chk1("t5_cpu_int", cpu_interrupt, 1'b1);
    irq_in = 8'h02;
    wr(PEND, 32'h4, 4'hF, e);
    irq_in = 8'h00;
    rd(PEND, d, e); chk("t5_set_wins", d, 32'h4);
    wr(PEND, 32'h4, 4'b0010, e);
    rd(PEND, d, e); chk("t5_w1c_strobe_masked", d, 32'h4);
    wr(PEND, 32'h4, 4'hF, e);
    rd(PEND, d, e); chk("t5_w1c_cleared", d, 32'h0);
    chk1("t5_cpu_int_off", cpu_interrupt, 1'b0);
    wr(ENA, 32'hFFFF_FFFF, 4'hF, e);
    rd(ENA, d, e); chk("t5_enable_width", d, 32'h1FF);
    wr(CAUS, 32'h1234_5678, 4'hF, e);
    chk1("t5_ro_write_perr", e, 1'b0);
    rd(CAUS, d, e); chk("t5_cause_none", d, 32'hFFFF_FFFF);

    // 6: asynchronous reset in the middle of an access
    @(posedge clk); #1; irq_in = 8'h80;
    @(posedge clk); #1; irq_in = 8'h00;
    rd(CAUS, d, e); chk("t6_cause", d, 32'h8);
    chk1("t6_cpu_int_set", cpu_interrupt, 1'b1);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h8000_0000;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #1; rts = 1'b1;
    #1;
    chk1("t6_cpu_int_in_reset", cpu_interrupt, 1'b0);
    bus.paddr = 32'h4000_0000;
    #1;
    chk("t6_reset_unmapped_bus", {30'h0, bus.pready, bus.perr}, 32'h3);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    rts = 1'b0;
    rd(PEND, d, e); chk("t6_pending_reset", d, 32'h0);
    rd(ENA,  d, e); chk("t6_enable_reset", d, 32'h0);
    rd(32'h0200_0020, d, e);
    chk1("t6_bad_offset_perr", e, 1'b1);
    rd(PEND, d, e); chk("t6_pending_after_bad", d, 32'h1);
    rd(EADR, d, e); chk("t6_erraddr_bad", d, 32'h0200_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
